// File: rtl/compare_pipe_sched.sv
// Round-robin front end for the shared 8-digit mixed-radix compare pipe: per-digit input skew,
// requester-id tag line aligned to the pipe latency, and a credit-protected FWFT result FIFO.
module compare_pipe_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DIG_WIDTH  = 18,
  parameter int unsigned NUM_DIG    = 8,
  parameter int unsigned PIPE_LAT   = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*NUM_DIG*DIG_WIDTH-1:0] req_digits_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [DIG_WIDTH-1:0]           cp_dig_0_o,
  output logic [DIG_WIDTH-1:0]           cp_dig_1_o,
  output logic [DIG_WIDTH-1:0]           cp_dig_2_o,
  output logic [DIG_WIDTH-1:0]           cp_dig_3_o,
  output logic [DIG_WIDTH-1:0]           cp_dig_4_o,
  output logic [DIG_WIDTH-1:0]           cp_dig_5_o,
  output logic [DIG_WIDTH-1:0]           cp_dig_6_o,
  output logic [DIG_WIDTH-1:0]           cp_dig_7_o,
  input  logic [1:0]                     cp_sign_in_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id_o,
  output logic [1:0]                     rsp_sign_o,
  output logic                           busy_o
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OpW  = NUM_DIG * DIG_WIDTH;

  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d, grant_id;
  logic [IdW:0]    cand_sum;
  logic            grant_found, issue, push, pop;
  logic [CntW-1:0] credit_q, credit_d, count_q, count_d;
  logic [OpW-1:0]  issue_ops;

  // Search from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand_sum    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IdW+1)'(i);
      if (cand_sum >= (IdW+1)'(NUM_REQ)) cand_sum = cand_sum - (IdW+1)'(NUM_REQ);
      if (!grant_found && req_valid_i[cand_sum[IdW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand_sum[IdW-1:0];
      end
    end
  end

  always_comb begin
    issue       = grant_found && (credit_q < CntW'(FIFO_DEPTH)) && !reset_i;
    req_ready_o = issue ? (NUM_REQ'(1) << grant_id) : '0;
    rr_ptr_d    = rr_ptr_q;
    if (issue) rr_ptr_d = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    issue_ops = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (IdW'(r) == grant_id) issue_ops = req_digits_i[r*OpW +: OpW];
    end
  end

  // Digit k sits behind k extra registers so the serial sign chain sees aligned operands.
  logic [DIG_WIDTH-1:0] cp_dig [NUM_DIG];
  for (genvar k = 0; k < NUM_DIG; k++) begin : g_skew
    logic [DIG_WIDTH-1:0] line_q [k+1];
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int j = 0; j <= k; j++) line_q[j] <= '0;
      end else begin
        line_q[0] <= issue ? issue_ops[k*DIG_WIDTH +: DIG_WIDTH] : '0;
        for (int j = 1; j <= k; j++) line_q[j] <= line_q[j-1];
      end
    end
    assign cp_dig[k] = line_q[k];
  end

  assign cp_dig_0_o = cp_dig[0];
  assign cp_dig_1_o = cp_dig[1];
  assign cp_dig_2_o = cp_dig[2];
  assign cp_dig_3_o = cp_dig[3];
  assign cp_dig_4_o = cp_dig[4];
  assign cp_dig_5_o = cp_dig[5];
  assign cp_dig_6_o = cp_dig[6];
  assign cp_dig_7_o = cp_dig[7];

  logic [PIPE_LAT:0] tag_vld_q;
  logic [IdW-1:0]    tag_id_q [PIPE_LAT+1];

  always_ff @(posedge clk_i) begin
    if (reset_i) tag_vld_q <= '0;
    else         tag_vld_q <= {tag_vld_q[PIPE_LAT-1:0], issue};
  end

  always_ff @(posedge clk_i) begin
    tag_id_q[0] <= grant_id;
    for (int j = 1; j <= PIPE_LAT; j++) tag_id_q[j] <= tag_id_q[j-1];
  end

  assign push = tag_vld_q[PIPE_LAT];

  logic [IdW+1:0]  mem_q [FIFO_DEPTH];
  logic [IdW+1:0]  rd_word;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rsp_valid_o = (count_q != '0);
    pop         = rsp_valid_o && rsp_ready_i;
    rd_word     = mem_q[rd_ptr_q];
    rsp_id_o    = rsp_valid_o ? rd_word[IdW+1:2] : '0;
    rsp_sign_o  = rsp_valid_o ? rd_word[1:0] : '0;
    busy_o      = (credit_q != '0);
    count_d     = count_q;
    credit_d    = credit_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    case ({issue, pop})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {tag_id_q[PIPE_LAT], cp_sign_in_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
      credit_q <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Credit accounting guarantees a push never meets a full FIFO without a matching pop.
  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(push && count_q == CntW'(FIFO_DEPTH) && !pop));
  end

endmodule

// File: tb/tb_compare_pipe_sched.sv
// Scoreboard bench for compare_pipe_sched with a behavioural serial-sign compare pipe model.
module tb_compare_pipe_sched;
  localparam int NR  = 4;
  localparam int DW  = 18;
  localparam int ND  = 8;
  localparam int PL  = 8;
  localparam int FD  = 16;
  localparam int OPW = ND * DW;
  localparam logic [DW-1:0] REF = 18'd5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*OPW-1:0] req_digits;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     cp_dig [ND];
  logic [1:0]        cp_sign_in;
  logic              rsp_valid, rsp_ready, busy;
  logic [1:0]        rsp_id, rsp_sign;

  compare_pipe_sched #(
    .NUM_REQ(NR), .DIG_WIDTH(DW), .NUM_DIG(ND), .PIPE_LAT(PL), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_digits_i(req_digits),
    .req_ready_o(req_ready),
    .cp_dig_0_o(cp_dig[0]), .cp_dig_1_o(cp_dig[1]), .cp_dig_2_o(cp_dig[2]),
    .cp_dig_3_o(cp_dig[3]), .cp_dig_4_o(cp_dig[4]), .cp_dig_5_o(cp_dig[5]),
    .cp_dig_6_o(cp_dig[6]), .cp_dig_7_o(cp_dig[7]),
    .cp_sign_in_i(cp_sign_in), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_sign_o(rsp_sign), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cnt = 0;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Pipe model: stage k folds digit k onto the sign from stage k-1 one cycle earlier.
  function automatic logic [1:0] stage_fn(input logic [DW-1:0] d, input logic [1:0] lower);
    if (d > REF) return 2'b01;
    if (d < REF) return 2'b10;
    return lower;
  endfunction

  logic [1:0] pipe_sign_q [ND];
  always @(posedge clk) begin
    pipe_sign_q[0] <= stage_fn(cp_dig[0], 2'b00);
    for (int k = 1; k < ND; k++) pipe_sign_q[k] <= stage_fn(cp_dig[k], pipe_sign_q[k-1]);
  end
  assign cp_sign_in = pipe_sign_q[ND-1];

  // Reference result: most significant differing digit decides.
  function automatic logic [1:0] ref_sign(input logic [OPW-1:0] ops);
    for (int k = ND - 1; k >= 0; k--) begin
      if (ops[k*DW +: DW] > REF) return 2'b01;
      if (ops[k*DW +: DW] < REF) return 2'b10;
    end
    return 2'b00;
  endfunction

  typedef struct {
    int         id;
    logic [1:0] sign;
    int         due;
  } exp_t;

  exp_t          sb[$];
  int            m_credit = 0;
  int            m_rr = 0;
  logic [OPW-1:0] m_skew [ND];
  logic [NR-1:0] e_ready;
  logic          e_valid, m_pop;
  logic [OPW-1:0] e_dig, g_dig;
  int            g;

  initial for (int k = 0; k < ND; k++) m_skew[k] = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    e_ready = '0;
    g = -1;
    if (!reset && m_credit < FD) begin
      for (int i = 0; i < NR; i++) begin
        if (g < 0 && req_valid[(m_rr + i) % NR]) g = (m_rr + i) % NR;
      end
      if (g >= 0) e_ready[g] = 1'b1;
    end
    check_eq("req_ready", req_ready, e_ready);
    if (req_valid & req_ready) acc_cnt++;
    e_valid = (sb.size() > 0) && (sb[0].due <= cyc);
    check_eq("rsp_valid", rsp_valid, e_valid);
    check_eq("busy", busy, m_credit != 0);
    for (int k = 0; k < ND; k++) begin
      e_dig[k*DW +: DW] = m_skew[k][k*DW +: DW];
      g_dig[k*DW +: DW] = cp_dig[k];
    end
    check_eq("cp_dig", g_dig, e_dig);
    m_pop = e_valid && rsp_ready;
    if (m_pop) begin
      check_eq("rsp_id", rsp_id, sb[0].id);
      check_eq("rsp_sign", rsp_sign, sb[0].sign);
      void'(sb.pop_front());
    end
    if (reset) begin
      sb.delete();
      m_credit = 0;
      m_rr = 0;
      for (int k = 0; k < ND; k++) m_skew[k] = '0;
    end else begin
      for (int k = ND - 1; k > 0; k--) m_skew[k] = m_skew[k-1];
      m_skew[0] = (g >= 0) ? req_digits[g*OPW +: OPW] : '0;
      if (g >= 0) begin
        sb.push_back('{id: g, sign: ref_sign(req_digits[g*OPW +: OPW]), due: cyc + 10});
        m_rr = (g + 1) % NR;
        m_credit++;
      end
      if (m_pop) m_credit--;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_digits();
    for (int i = 0; i < NR * ND; i++) req_digits[i*DW +: DW] = DW'($urandom_range(4, 6));
  endtask

  task automatic wait_idle(input int bound);
    int i = 0;
    while ((sb.size() != 0 || m_credit != 0) && i < bound) begin
      next_cycle();
      i++;
    end
    check_eq("drain_left", sb.size(), 0);
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);
    next_cycle();
  endtask

  int acc0;

  initial begin
    reset = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_digits = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check_eq("reset_rsp_id", rsp_id, 2'd0);
    check_eq("reset_rsp_sign", rsp_sign, 2'd0);
    check_eq("reset_rsp_valid", rsp_valid, 1'b0);

    // Single request from requester 2, digits 1..8, accepted in cycle 5.
    while (cyc < 5) next_cycle();
    for (int k = 0; k < ND; k++) req_digits[2*OPW + k*DW +: DW] = DW'(k + 1);
    req_valid = 4'b0100;
    next_cycle();
    req_valid = '0;
    while (cyc < 15) next_cycle();
    @(negedge clk);
    check_eq("single_rsp_valid_c15", rsp_valid, 1'b1);
    check_eq("single_rsp_id", rsp_id, 2'd2);
    check_eq("single_rsp_sign", rsp_sign, 2'b01);
    wait_idle(50);

    // Fairness: all requesters valid continuously.
    req_valid = '1;
    for (int i = 0; i < 24; i++) begin
      rand_digits();
      next_cycle();
    end
    req_valid = '0;
    wait_idle(60);

    // Backpressure: exactly FIFO_DEPTH accepts with rsp_ready low.
    rsp_ready = 1'b0;
    req_valid = '1;
    acc0 = acc_cnt;
    for (int i = 0; i < 30; i++) begin
      rand_digits();
      next_cycle();
    end
    check_eq("bp_accepts", acc_cnt - acc0, FD);
    acc0 = acc_cnt;
    rsp_ready = 1'b1;
    next_cycle();
    rsp_ready = 1'b0;
    repeat (5) next_cycle();
    check_eq("bp_one_more", acc_cnt - acc0, 1);
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(80);

    // Random traffic with random response backpressure.
    for (int i = 0; i < 200; i++) begin
      req_valid = NR'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_digits();
      next_cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(80);

    // Reset mid-flight.
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      rand_digits();
      next_cycle();
    end
    req_valid = '0;
    repeat (3) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_eq("busy_after_reset", busy, 1'b0);
    next_cycle();
    rand_digits();
    req_valid = 4'b0010;
    next_cycle();
    req_valid = '0;
    wait_idle(40);

    // Bubbles: requests in alternate cycles.
    for (int i = 0; i < 12; i++) begin
      rand_digits();
      req_valid = NR'($urandom_range(1, 15));
      next_cycle();
      req_valid = '0;
      next_cycle();
    end
    wait_idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
